// File: rtl/softmax_max_seq.sv
// ---------------------------------------------------------------------------
// softmax_max_seq
//
// Sequencer for the pipelined max-tree stage of the softmax datapath.
// On a start command it clears the external max tree, streams exactly len
// elements from the upstream source into the tree, waits out the tree
// latency, captures the tree's running max (Xmax) and offers it downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until that edge; ready
// may be raised or lowered freely.
//
// Ports
//   clock_i, reset_i     : clock, synchronous active-high reset
//   start_i, len_i       : start command and vector length (IDLE only)
//   busy_o               : high whenever the sequencer is not IDLE
//   in_valid_i/in_data_i : upstream element stream
//   in_ready_o           : element accepted this cycle when in_valid_i=1
//   tree_clear_o         : one-cycle pulse clearing the tree's running max
//   tree_valid_o/_data_o : registered element feed into the tree
//   tree_max_i           : tree running max (TREE_LAT cycles behind the feed)
//   max_valid_o/_data_o  : Xmax result to the subtract/exp stages
//   max_ready_i          : downstream accepts Xmax
// ---------------------------------------------------------------------------
module softmax_max_seq #(
    parameter int DATA_W   = 31,
    parameter int LEN_W    = 8,
    parameter int TREE_LAT = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              tree_clear_o,
    output logic              tree_valid_o,
    output logic [DATA_W-1:0] tree_data_o,
    input  logic [DATA_W-1:0] tree_max_i,
    output logic              max_valid_o,
    output logic [DATA_W-1:0] max_data_o,
    input  logic              max_ready_i
);

    // Drain counter must be able to hold the value TREE_LAT.
    localparam int DRAIN_W = $clog2(TREE_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                tree_valid_q, tree_valid_d;
    logic [DATA_W-1:0]   tree_data_q, tree_data_d;
    logic                max_valid_q, max_valid_d;
    logic [DATA_W-1:0]   max_data_q, max_data_d;

    logic accept;
    logic last_elem;
    logic drain_done;

    assign accept     = in_valid_i && in_ready_o;
    assign last_elem  = (count_q == (len_q - LEN_W'(1)));
    // DRAIN is entered the cycle the last element is on tree_valid_o; the
    // tree reflects it TREE_LAT cycles later, so sample after TREE_LAT+1
    // DRAIN cycles.
    assign drain_done = (drain_q == DRAIN_W'(TREE_LAT));

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            len_q        <= '0;
            drain_q      <= '0;
            tree_valid_q <= 1'b0;
            tree_data_q  <= '0;
            max_valid_q  <= 1'b0;
            max_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            drain_q      <= drain_d;
            tree_valid_q <= tree_valid_d;
            tree_data_q  <= tree_data_d;
            max_valid_q  <= max_valid_d;
            max_data_q   <= max_data_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i && (len_i != '0)) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED:  if (accept && last_elem) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_DONE;
            ST_DONE:  if (max_valid_q && max_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        count_d      = count_q;
        len_d        = len_q;
        drain_d      = drain_q;
        tree_valid_d = accept;
        tree_data_d  = accept ? in_data_i : tree_data_q;
        max_valid_d  = max_valid_q;
        max_data_d   = max_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    len_d   = len_i;
                    count_d = '0;
                end
            end
            ST_FEED: begin
                if (accept) begin
                    // Return to zero on the last element so count stays <= len-1.
                    count_d = last_elem ? '0 : count_q + LEN_W'(1);
                    if (last_elem) drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    drain_d     = '0;
                    max_valid_d = 1'b1;
                    max_data_d  = tree_max_i;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                if (max_valid_q && max_ready_i) max_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        in_ready_o   = (state_q == ST_FEED);
        tree_clear_o = (state_q == ST_CLEAR);
        tree_valid_o = tree_valid_q;
        tree_data_o  = tree_data_q;
        max_valid_o  = max_valid_q;
        max_data_o   = max_data_q;
    end

endmodule

// File: tb/tb_softmax_max_seq.sv
// ---------------------------------------------------------------------------
// tb_softmax_max_seq
//
// Drives vectors into softmax_max_seq, models the external max tree, and
// checks each Xmax result against the plain maximum of the issued vector.
// ---------------------------------------------------------------------------
module tb_softmax_max_seq;

  localparam int DATA_W   = 31;
  localparam int LEN_W    = 8;
  localparam int TREE_LAT = 2;

  logic              clk;
  logic              reset_i;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              tree_clear_o;
  logic              tree_valid_o;
  logic [DATA_W-1:0] tree_data_o;
  logic [DATA_W-1:0] tree_max_i;
  logic              max_valid_o;
  logic [DATA_W-1:0] max_data_o;
  logic              max_ready_i;

  softmax_max_seq #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .TREE_LAT(TREE_LAT)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .tree_clear_o(tree_clear_o),
    .tree_valid_o(tree_valid_o),
    .tree_data_o (tree_data_o),
    .tree_max_i  (tree_max_i),
    .max_valid_o (max_valid_o),
    .max_data_o  (max_data_o),
    .max_ready_i (max_ready_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- max tree model ----------------
  // Stage 0 holds the running max (visible one cycle after the element),
  // the remaining stages add latency up to TREE_LAT.
  logic [DATA_W-1:0] tree_pipe [TREE_LAT];
  always @(posedge clk) begin
    if (tree_clear_o) tree_pipe[0] <= '0;
    else if (tree_valid_o && (tree_data_o > tree_pipe[0])) tree_pipe[0] <= tree_data_o;
    for (int k = 1; k < TREE_LAT; k++) tree_pipe[k] <= tree_pipe[k-1];
  end
  assign tree_max_i = tree_pipe[TREE_LAT-1];

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_len_q[$];
  logic [DATA_W-1:0] job_data [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  int                clear_cnt = 0;
  int                acc_job = 0;
  int                tv_job = 0;
  int                last_acc_cyc = 0;
  logic              prev_mv = 1'b0;
  logic              prev_hs = 1'b0;
  logic [DATA_W-1:0] prev_md = '0;

  always @(negedge clk) begin
    if (reset_i) begin
      prev_mv = 1'b0;
      prev_hs = 1'b0;
      acc_job = 0;
      tv_job  = 0;
    end else begin
      if (tree_clear_o) begin
        clear_cnt++;
        acc_job = 0;
        tv_job  = 0;
      end
      if (in_valid_i && in_ready_o) begin
        acc_job++;
        last_acc_cyc = cyc;
      end
      if (tree_valid_o) tv_job++;
      if (max_valid_o && !prev_mv) chk("result_latency", cyc - last_acc_cyc, TREE_LAT + 2);
      if (prev_mv && !prev_hs) begin
        chk("hold_max_valid", {31'd0, max_valid_o}, 32'd1);
        chk("hold_max_data", {1'b0, max_data_o}, {1'b0, prev_md});
      end
      if (max_valid_o && max_ready_i) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: got 0x%0h with no result pending", max_data_o);
        end else begin
          logic [DATA_W-1:0] e;
          int l;
          e = exp_q.pop_front();
          l = exp_len_q.pop_front();
          chk("max_data", {1'b0, max_data_o}, {1'b0, e});
          chk("accept_count", acc_job, l);
          chk("tree_valid_count", tv_job, l);
        end
      end
      prev_mv = max_valid_o;
      prev_md = max_data_o;
      prev_hs = max_valid_o && max_ready_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input int len);
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i   = LEN_W'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int len, input int gap_lo, input int gap_hi);
    for (int i = 0; i < len; i++) begin
      bit got = 1'b0;
      int budget = 0;
      in_valid_i = 1'b1;
      in_data_i  = job_data[i];
      while (!got && budget < 100) begin
        @(negedge clk);
        got = in_ready_o;
        @(posedge clk); #1;
        budget++;
      end
      if (!got) begin
        total_cnt++;
        $display("FAIL feed_timeout: element %0d never accepted", i);
      end
      in_valid_i = 1'b0;
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic finish_job(input int ready_delay, input bit start_in_done);
    int b = 0;
    int clr0;
    @(negedge clk);
    while (!max_valid_o && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!max_valid_o) begin
      total_cnt++;
      $display("FAIL result_timeout: max_valid_o never asserted");
    end
    clr0 = clear_cnt;
    for (int d = 0; d < ready_delay; d++) begin
      chk("busy_in_done", {31'd0, busy_o}, 32'd1);
      @(posedge clk); #1;
      start_i = start_in_done && (d == 0);
      len_i   = 8'd3;
      @(negedge clk);
    end
    @(posedge clk); #1;
    max_ready_i = 1'b1;
    start_i     = start_in_done;
    len_i       = 8'd3;
    @(posedge clk); #1;
    max_ready_i = 1'b0;
    start_i     = 1'b0;
    @(negedge clk);
    chk("busy_after_handshake", {31'd0, busy_o}, 32'd0);
    chk("valid_after_handshake", {31'd0, max_valid_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("no_clear_after_done", clear_cnt, clr0);
    chk("idle_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic run_job(input int len, input int gap_lo, input int gap_hi,
                         input int ready_delay, input bit start_in_done);
    logic [DATA_W-1:0] m = '0;
    int clr0;
    for (int i = 0; i < len; i++) if (job_data[i] > m) m = job_data[i];
    exp_q.push_back(m);
    exp_len_q.push_back(len);
    clr0 = clear_cnt;
    start_job(len);
    feed(len, gap_lo, gap_hi);
    chk("one_clear_pulse", clear_cnt, clr0 + 1);
    finish_job(ready_delay, start_in_done);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       {31'd0, busy_o},       32'd0);
    chk({tag, "_in_ready"},   {31'd0, in_ready_o},   32'd0);
    chk({tag, "_tree_clear"}, {31'd0, tree_clear_o}, 32'd0);
    chk({tag, "_tree_valid"}, {31'd0, tree_valid_o}, 32'd0);
    chk({tag, "_max_valid"},  {31'd0, max_valid_o},  32'd0);
    chk({tag, "_tree_data"},  {1'b0, tree_data_o},   32'd0);
    chk({tag, "_max_data"},   {1'b0, max_data_o},    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int clr0;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    len_i       = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    max_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_i = 1'b0;

    // back-to-back stream
    job_data[0] = 31'd5; job_data[1] = 31'd17; job_data[2] = 31'd3; job_data[3] = 31'd9;
    run_job(4, 0, 0, 0, 1'b0);

    // same data with 3-cycle gaps between elements
    run_job(4, 3, 3, 1, 1'b0);

    // single element at the top of the range
    job_data[0] = 31'h7FFF_FFFF;
    run_job(1, 0, 0, 0, 1'b0);

    // downstream stalls in DONE while start_i is pulsed
    job_data[0] = 31'd40; job_data[1] = 31'd2; job_data[2] = 31'd41; job_data[3] = 31'd7;
    run_job(4, 0, 1, 5, 1'b1);

    // zero-length start is ignored
    clr0 = clear_cnt;
    start_job(0);
    repeat (4) begin
      @(negedge clk);
      chk("len0_busy", {31'd0, busy_o}, 32'd0);
    end
    chk("len0_no_clear", clear_cnt, clr0);

    // reset after two of four accepts
    job_data[0] = 31'd1000; job_data[1] = 31'd900; job_data[2] = 31'd5; job_data[3] = 31'd6;
    start_job(4);
    feed(2, 0, 0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    job_data[0] = 31'd1; job_data[1] = 31'd2;
    run_job(2, 0, 0, 0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      int len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(7, 0) == 0) job_data[i] = 31'h7FFF_FFFF;
        else job_data[i] = DATA_W'($urandom());
      end
      run_job(len, 0, $urandom_range(3, 0), $urandom_range(4, 0), 1'($urandom_range(1, 0)));
    end

    chk("results_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
